run_ctrl: RTL and testbench
===========================

# run_ctrl

Run controller for the tinyarch core: owns the program counter and sequences instruction fetch from the instruction memory. It services the top-level req/ack start/done handshake. On each request it runs the program from address 0 until a halt instruction, stalling and branching on datapath command. It sits between the top-level handshake pins and the instruction memory/datapath.

## Interface
Parameters:
- IADDR_W, 8, instruction memory address / PC width
- INSTR_W, 9, instruction width
- HALT_OP, 9'h1FF, instruction encoding that ends a run

Ports:
- clk  in  1  clock; everything is on the rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  start request from the testbench/host (level)
- ack  out  1  run complete
- imem_addr  out  IADDR_W  instruction memory address (= PC)
- imem_rd  out  1  instruction memory read enable
- imem_data  in  INSTR_W  instruction memory read data, combinational from imem_addr
- instr  out  INSTR_W  current instruction to the datapath
- instr_valid  out  1  instr is live; the datapath commits when instr_valid && !stall
- stall  in  1  datapath needs another cycle on the current instruction
- branch_taken  in  1  the current instruction redirects the PC
- branch_target  in  IADDR_W  redirect address
- run_cycles  out  16  cycles spent in the last or current run (see Configuration)

## Operation
- States: IDLE, FETCH, EXEC, DONE (enum in package).
- IDLE:
  - ack=0, imem_rd=0, instr_valid=0.
  - req=1 → PC:=0, go FETCH.
- FETCH:
  - imem_rd=1, imem_addr=PC.
  - IR:=imem_data at the cycle's end; go EXEC.
- EXEC:
  - instr=IR, instr_valid=1, imem_rd=0.
  - Decisions are made in priority order:
    1. IR==HALT_OP → DONE. stall and branch_taken are ignored.
    2. stall=1 → stay in EXEC. PC and IR hold.
    3. branch_taken=1 → PC:=branch_target, go FETCH.
    4. Otherwise PC:=PC+1 modulo 2^IADDR_W, go FETCH. The PC wraps from all-ones to 0 with no error.
- DONE:
  - ack=1.
  - Stays while req=1; req=0 → IDLE (four-phase handshake).
- req is sampled only in IDLE and DONE; req deasserting mid-run is ignored. If req is already low on DONE entry, ack is a one-cycle pulse.
- imem_addr always equals PC, including in IDLE.

## Timing
- Reset values: state=IDLE, PC=0, IR=0, ack=0, imem_rd=0, instr_valid=0, instr=0, imem_addr=0, run_cycles=0.
- Reset mid-run aborts immediately, taking effect on the next edge; no ack is issued.
- req sampled high in IDLE at edge N gives FETCH in cycle N+1 and EXEC in cycle N+2.
- Each unstalled instruction takes 2 cycles (FETCH+EXEC); each stall cycle adds 1.
- A HALT at address k reached without branches or stalls: ack rises 2(k+1) cycles after FETCH is first entered.
- branch_taken and branch_target are sampled only in EXEC with stall=0; ignored elsewhere.
- IDLE with req=1 held continuously after DONE→IDLE starts a new run on the next edge.

## Configuration
- RUN_CTRL_CYCLE_COUNT_EN defined:
  - 16-bit counter cleared on IDLE→FETCH.
  - Increments every cycle in FETCH or EXEC and saturates at 16'hFFFF.
  - Holds its value in DONE and IDLE until the next run starts; drives run_cycles.
- RUN_CTRL_CYCLE_COUNT_EN undefined: run_cycles tied to 0; no counter logic.

## Structure
- run_ctrl_pkg holds:
  - the run_state_t enum (IDLE, FETCH, EXEC, DONE)
  - default HALT_OP
  - RUN_CYCLES_W=16
- One sub-module, sat_counter (width-parameterised saturating counter with clear/enable). It is instantiated only under RUN_CTRL_CYCLE_COUNT_EN.
- The FSM, PC and IR stay in run_ctrl.

## Test plan
- Reset mid-EXEC, with req still high:
  - reset response: next cycle state IDLE, ack=0, PC=0.
  - After reset release: a new run starts, FETCH at address 0.
- Straight-line program, HALT at address 3, req held high:
  - ack rises 8 cycles after the first FETCH and stays high until req drops.
  - run_cycles=8 with the macro defined, 0 without.
- Instruction at address 1 asserts stall for 3 cycles:
  - instr_valid stays high with unchanged instr for 4 EXEC cycles.
  - PC then becomes 2; total run_cycles grows by 3.
- Branch at address 2 with target 8'h10, HALT at 8'h10:
  - imem_addr sequence is 0, 1, 2, 0x10.
  - ack follows EXEC of 0x10.
- PC wrap:
  - no HALT below 8'hFF, and 8'hFF holds a non-halt instruction → next fetch is address 0.
  - HALT at address 0 on the second pass ends the run.
- HALT with branch_taken=1 and stall=1 in the same EXEC cycle → DONE next cycle, PC unchanged.
- req pulsed low during the run → run completes anyway; ack is a single-cycle pulse.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and constants for the tinyarch run controller.
// Contents:
//   run_state_t     - controller FSM state encoding
//   DEFAULT_HALT_OP - instruction encoding that ends a run
//   RUN_CYCLES_W    - width of the run cycle counter / run_cycles_o
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StExec,
        StDone
    } run_state_t;

    localparam logic [8:0]  DEFAULT_HALT_OP = 9'h1FF;
    localparam int unsigned RUN_CYCLES_W    = 16;

endpackage : run_ctrl_pkg

// File: rtl/run_ctrl_sat_counter.sv
// sat_counter: width-parameterised up counter that sticks at all-ones.
// Ports:
//   clk_i   - clock, rising edge
//   reset_i - synchronous active-high reset, clears the count
//   clr_i   - synchronous clear (wins over en_i)
//   en_i    - count enable
//   cnt_o   - current count
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/run_ctrl.sv
// run_ctrl: run controller for the tinyarch core. Owns the PC and the
// instruction register, fetches from instruction memory and presents each
// instruction to the datapath until a HALT, then completes a four-phase
// req/ack handshake.
// Optional feature: define RUN_CTRL_CYCLE_COUNT_EN to count FETCH/EXEC cycles
// of each run on run_cycles_o; otherwise run_cycles_o is tied to 0.
// Ports:
//   clk_i           - clock, rising edge
//   reset_i         - synchronous active-high reset
//   req_i           - start request (level)
//   ack_o           - run complete
//   imem_addr_o     - instruction memory address (always the PC)
//   imem_rd_o       - instruction memory read enable (FETCH)
//   imem_data_i     - instruction memory read data (combinational)
//   instr_o         - current instruction to the datapath
//   instr_valid_o   - instr_o is live (EXEC)
//   stall_i         - datapath holds the current instruction
//   branch_taken_i  - current instruction redirects the PC
//   branch_target_i - redirect address
//   run_cycles_o    - cycles spent in the last or current run
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned        IADDR_W = 8,
    parameter int unsigned        INSTR_W = 9,
    parameter logic [INSTR_W-1:0] HALT_OP = INSTR_W'(DEFAULT_HALT_OP)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    req_i,
    output logic                    ack_o,
    output logic [IADDR_W-1:0]      imem_addr_o,
    output logic                    imem_rd_o,
    input  logic [INSTR_W-1:0]      imem_data_i,
    output logic [INSTR_W-1:0]      instr_o,
    output logic                    instr_valid_o,
    input  logic                    stall_i,
    input  logic                    branch_taken_i,
    input  logic [IADDR_W-1:0]      branch_target_i,
    output logic [RUN_CYCLES_W-1:0] run_cycles_o
);

    run_state_t         state_q, state_d;
    logic [IADDR_W-1:0] pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        ack_o         = 1'b0;
        imem_rd_o     = 1'b0;
        instr_valid_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    pc_d    = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                imem_rd_o = 1'b1;
                ir_d      = imem_data_i;
                state_d   = StExec;
            end
            StExec: begin
                instr_valid_o = 1'b1;
                // HALT overrides stall and branch; stall overrides branch.
                if (ir_q == HALT_OP) begin
                    state_d = StDone;
                end else if (stall_i) begin
                    state_d = StExec;
                end else if (branch_taken_i) begin
                    pc_d    = branch_target_i;
                    state_d = StFetch;
                end else begin
                    pc_d    = pc_q + IADDR_W'(1);  // wraps naturally
                    state_d = StFetch;
                end
            end
            StDone: begin
                ack_o = 1'b1;
                if (!req_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign imem_addr_o = pc_q;
    assign instr_o     = ir_q;

`ifdef RUN_CTRL_CYCLE_COUNT_EN
    logic run_start;
    logic run_busy;

    assign run_start = (state_q == StIdle) && req_i;
    assign run_busy  = (state_q == StFetch) || (state_q == StExec);

    sat_counter #(
        .Width(RUN_CYCLES_W)
    ) u_cycle_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clr_i  (run_start),
        .en_i   (run_busy),
        .cnt_o  (run_cycles_o)
    );
`else
    assign run_cycles_o = '0;
`endif

endmodule : run_ctrl

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed self-checking bench for run_ctrl.
module tb_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        ack;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [8:0]  imem_data;
    logic [8:0]  instr;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [15:0] run_cycles;

    logic [8:0] mem [256];
    int n_pass  = 0;
    int n_total = 0;
    int n;

    localparam logic [8:0] HALT = 9'h1FF;

    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    run_ctrl u_dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .req_i          (req),
        .ack_o          (ack),
        .imem_addr_o    (imem_addr),
        .imem_rd_o      (imem_rd),
        .imem_data_i    (imem_data),
        .instr_o        (instr),
        .instr_valid_o  (instr_valid),
        .stall_i        (stall),
        .branch_taken_i (branch_taken),
        .branch_target_i(branch_target),
        .run_cycles_o   (run_cycles)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Steps until ack or the bound expires; n is the number of edges taken.
    task automatic wait_ack(output int cnt);
        cnt = 0;
        while (!ack && cnt < 40) begin
            step();
            cnt++;
        end
    endtask

    function automatic logic [31:0] exp_rc(input int cycles);
`ifdef RUN_CTRL_CYCLE_COUNT_EN
        return 32'(cycles);
`else
        return 32'(cycles * 0);
`endif
    endfunction

    task automatic fill_nop();
        for (int i = 0; i < 256; i++) mem[i] = 9'(i + 1);
        mem[255] = 9'h0AA;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 8'h00;
        fill_nop();
        mem[0] = 9'h011; mem[1] = 9'h022; mem[2] = 9'h033; mem[3] = HALT;
        step(); step();
        chk("rst_ack", ack, 0);
        chk("rst_rd", imem_rd, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_cycles", run_cycles, 0);
        reset = 1'b0;

        // Reset in the middle of EXEC with req held high.
        req = 1'b1;
        step();
        chk("r_fetch0", imem_rd, 1);
        step();
        chk("r_exec0_valid", instr_valid, 1);
        chk("r_exec0_instr", instr, 9'h011);
        reset = 1'b1;
        step();
        chk("r_abort_ack", ack, 0);
        chk("r_abort_valid", instr_valid, 0);
        chk("r_abort_rd", imem_rd, 0);
        chk("r_abort_addr", imem_addr, 0);
        reset = 1'b0;

        // Restart and run straight-line program, HALT at 3.
        step();
        chk("s_fetch_rd", imem_rd, 1);
        chk("s_fetch_addr", imem_addr, 0);
        wait_ack(n);
        chk("s_ack_latency", n, 8);
        chk("s_cycles", run_cycles, exp_rc(8));
        step();
        chk("s_ack_hold1", ack, 1);
        step();
        chk("s_ack_hold2", ack, 1);
        req = 1'b0;
        step();
        chk("s_idle_ack", ack, 0);
        chk("s_idle_rd", imem_rd, 0);

        // Stall at address 1 for 3 cycles.
        req = 1'b1;
        step(); step(); step(); step();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) stall = 1'b0;
            chk("st_valid", instr_valid, 1);
            chk("st_instr", instr, 9'h022);
            chk("st_addr", imem_addr, 1);
            step();
        end
        chk("st_next_addr", imem_addr, 2);
        chk("st_next_rd", imem_rd, 1);
        wait_ack(n);
        chk("st_ack_latency", n, 4);
        chk("st_cycles", run_cycles, exp_rc(11));
        req = 1'b0;
        step();

        // Branch at address 2 to 0x10 where a HALT sits.
        mem[8'h10] = HALT;
        req = 1'b1;
        step();
        chk("b_addr0", imem_addr, 8'h00);
        step(); step();
        chk("b_addr1", imem_addr, 8'h01);
        step(); step();
        chk("b_addr2", imem_addr, 8'h02);
        step();
        branch_taken = 1'b1; branch_target = 8'h10;
        step();
        branch_taken = 1'b0; branch_target = 8'h00;
        chk("b_addr10", imem_addr, 8'h10);
        chk("b_addr10_rd", imem_rd, 1);
        step();
        chk("b_exec_halt", instr, HALT);
        chk("b_no_ack_yet", ack, 0);
        step();
        chk("b_ack", ack, 1);
        chk("b_cycles", run_cycles, exp_rc(8));
        req = 1'b0;
        step();

        // PC wrap: branch to 0xFE, run through 0xFF to 0, HALT there.
        fill_nop();
        req = 1'b1;
        step(); step();
        chk("w_instr0", instr, 9'h001);
        mem[0] = HALT;
        branch_taken = 1'b1; branch_target = 8'hFE;
        step();
        branch_taken = 1'b0; branch_target = 8'h00;
        chk("w_addr_fe", imem_addr, 8'hFE);
        step(); step();
        chk("w_addr_ff", imem_addr, 8'hFF);
        step();
        chk("w_instr_ff", instr, 9'h0AA);
        step();
        chk("w_wrap_addr", imem_addr, 8'h00);
        chk("w_wrap_rd", imem_rd, 1);
        step();
        chk("w_instr_halt", instr, HALT);
        step();
        chk("w_ack", ack, 1);
        req = 1'b0;
        step();

        // HALT with stall and branch asserted in the same EXEC cycle.
        fill_nop();
        mem[1] = HALT;
        req = 1'b1;
        step(); step(); step(); step();
        chk("h_exec_halt", instr, HALT);
        stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h55;
        step();
        chk("h_ack", ack, 1);
        chk("h_pc_hold", imem_addr, 8'h01);
        stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        // One low cycle of req returns to IDLE; raising it again restarts.
        req = 1'b0;
        step();
        chk("h_idle", ack, 0);
        req = 1'b1;
        step();
        chk("h_restart_rd", imem_rd, 1);
        chk("h_restart_addr", imem_addr, 0);
        wait_ack(n);
        chk("h_restart_latency", n, 4);
        req = 1'b0;
        step();

        // req dropped mid-run: run still completes, ack is a one-cycle pulse.
        fill_nop();
        mem[3] = HALT;
        req = 1'b1;
        step();
        req = 1'b0;
        wait_ack(n);
        chk("p_ack_latency", n, 8);
        chk("p_ack", ack, 1);
        step();
        chk("p_ack_pulse", ack, 0);
        chk("p_idle_rd", imem_rd, 0);
        step();
        chk("p_stay_idle", imem_rd, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_run_ctrl
